mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Moore-style control sequencer for the multi-cycle MIPS datapath.
- The datapath has one shared instruction/data memory plus IR, A/B, ALUOut and MDR registers.
- Each instruction is split into FETCH/DECODE/EXECUTE/MEM/WB steps, and the block emits one set of datapath strobes per step.
- Memory access uses a ready handshake that inserts wait states, with a timeout that traps.
- The block also keeps a retired-instruction counter.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 16, consecutive not-ready cycles allowed in one memory state before trapping; 0 disables the timeout.

Ports:
- clock_in  input  1  system clock; all state changes on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- opcode_in  input  6  IR[31:26]; sampled in DECODE and MEMADR.
- mem_ready_in  input  1  memory completes the current access in this cycle.
- pcWrite_out  output  1  unconditional PC load.
- pcWriteCond_out  output  1  PC load qualified by the ALU zero flag.
- iorD_out  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead_out  output  1  memory read request.
- memWrite_out  output  1  memory write request.
- irWrite_out  output  1  IR load.
- memtoReg_out  output  1  register write data select: 1 = MDR, 0 = ALUOut.
- regDst_out  output  1  destination register select: 1 = rd, 0 = rt.
- regWrite_out  output  1  register-file write.
- aluSrcA_out  output  1  ALU A select: 0 = PC, 1 = A.
- aluSrcB_out  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- aluOp_out  output  2  ALU operation: 00 = add, 01 = sub, 10 = use funct.
- pcSource_out  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state_out  output  4  current state encoding, for debug.
- halted_out  output  1  high while in TRAP.
- timeout_out  output  1  sticky flag: the trap was caused by a memory timeout.
- instr_count_out  output  COUNT_WIDTH  number of retired instructions.

Behaviour:
- Reset (sync, active-high): at the edge, state <= IDLE, counter <= 0, wait counter <= 0, timeout flag <= 0. While reset_in is high, all strobes are combinationally forced to 0.
- Outputs are decoded from the state register only, except irWrite_out and pcWrite_out in FETCH. Every strobe not listed for a state is 0.
- Supported opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000.
- IDLE: all strobes 0 -> FETCH.
- FETCH: memRead = 1, iorD = 0, aluSrcA = 0, aluSrcB = 01, aluOp = 00, pcSource = 00.
  - irWrite and pcWrite equal mem_ready_in.
  - When ready -> DECODE; otherwise stay.
- DECODE: aluSrcA = 0, aluSrcB = 11, aluOp = 00. Next state by opcode:
  - R -> EXECUTE
  - LW/SW -> MEMADR
  - ADDI -> ADDI_EX
  - BEQ -> BRANCH
  - J -> JUMP
  - anything else -> TRAP
- MEMADR: aluSrcA = 1, aluSrcB = 10, aluOp = 00 -> MEMREAD for LW, MEMWRITE for SW.
- MEMREAD: memRead = 1, iorD = 1; when ready -> MEMWB.
- MEMWB: memtoReg = 1, regDst = 0, regWrite = 1 -> FETCH.
- MEMWRITE: memWrite = 1, iorD = 1; when ready -> FETCH.
- EXECUTE: aluSrcA = 1, aluSrcB = 00, aluOp = 10 -> ALUWB.
- ALUWB: regDst = 1, memtoReg = 0, regWrite = 1 -> FETCH.
- ADDI_EX: aluSrcA = 1, aluSrcB = 10, aluOp = 00 -> ADDI_WB.
- ADDI_WB: regDst = 0, regWrite = 1 -> FETCH.
- BRANCH: aluSrcA = 1, aluSrcB = 00, aluOp = 01, pcWriteCond = 1, pcSource = 01 -> FETCH.
- JUMP: pcWrite = 1, pcSource = 10 -> FETCH.
- TRAP: all strobes 0, halted_out = 1; terminal until reset_in.
- Cycles per instruction with zero wait states:
  - R, ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ, J: 3
  - Each not-ready cycle in a memory state adds 1.
- Request hold rule: memRead/memWrite stay asserted and iorD stays stable throughout a wait.
- Retire counter: increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, ADDI_WB, BRANCH or JUMP. It wraps modulo 2^COUNT_WIDTH.
- Timeout, applies in FETCH, MEMREAD and MEMWRITE:
  - The wait counter clears on entering a memory state and on ready.
  - It increments on each not-ready cycle.
  - When the wait count reaches TIMEOUT_CYCLES: -> TRAP and timeout_out <= 1. memWrite is low from the next cycle.
  - A ready in the same cycle the limit is reached takes priority (normal transition, no trap).
- Reset mid-access, e.g. during MEMWRITE: strobes drop in the same cycle; IDLE follows.

Decomposition:
- Package mips_mc_pkg holds:
  - state_t enum: IDLE = 0, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, ADDI_EX, ADDI_WB, BRANCH, JUMP, TRAP.
  - Opcode constants.
  - ALUOP_*, SRCB_* and PCSRC_* constants.
- One natural sub-module: mips_mc_wait_timer (wait counter plus timeout compare).

Test Plan:
- Reset: hold reset_in 2 cycles, then release -> IDLE with all strobes 0, FETCH on the next cycle, instr_count_out = 0.
- R-type, ready tied 1: FETCH, DECODE, EXECUTE, ALUWB; regWrite = 1 and regDst = 1 in cycle 4; instr_count_out = 1 after 4 cycles.
- LW with ready low 2 cycles in MEMREAD: 7 cycles total; memRead and iorD held during the wait; memtoReg = 1 and regWrite = 1 in MEMWB.
- BEQ then J: BEQ shows pcWriteCond = 1, aluOp = 01, pcSource = 01; J shows pcWrite = 1, pcSource = 10; instr_count_out = 2 after 6 cycles.
- Opcode 111111 -> TRAP after DECODE; halted_out = 1, timeout_out = 0, all strobes 0 for 10+ cycles.
- SW with ready held 0, TIMEOUT_CYCLES = 16 -> TRAP after 16 wait cycles, timeout_out = 1. Separately, reset asserted during MEMWRITE -> memWrite = 0 in that cycle, then IDLE.

Source files
------------

// File: rtl/mips_mc_pkg.sv
`default_nettype none
// ============================================================================
// mips_mc_pkg: state, opcode and datapath-select encodings for mips_mc_control.
// Rev 1.0
// ============================================================================
package mips_mc_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    ALUWB    = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that talk to memory and therefore wait on the ready handshake.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mc_wait_timer.sv
`default_nettype none
// ============================================================================
// mips_mc_wait_timer: counts consecutive not-ready memory cycles, flags expiry.
// Rev 1.0
// ============================================================================
module mips_mc_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ready_i,
  output logic expire_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, active_i, ready_i};
    assign expire_o      = 1'b0;
  end else begin : g_enabled
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] wait_q;
    logic [W-1:0] wait_d;
    logic         at_limit;

    // Expiry fires on the not-ready cycle that would make the count hit the limit.
    assign at_limit = active_i && !ready_i && (wait_q == LIMIT);

    always_comb begin
      wait_d = wait_q;
      if (!active_i || ready_i || at_limit) begin
        wait_d = '0;
      end else begin
        wait_d = wait_q + W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_d;
      end
    end

    assign expire_o = at_limit;
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// mips_mc_control: Moore control sequencer for the multi-cycle MIPS datapath.
// Rev 1.0
// ============================================================================
module mips_mc_control #(
  parameter int COUNT_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic [5:0]             opcode_in,
  input  logic                   mem_ready_in,
  output logic                   pcWrite_out,
  output logic                   pcWriteCond_out,
  output logic                   iorD_out,
  output logic                   memRead_out,
  output logic                   memWrite_out,
  output logic                   irWrite_out,
  output logic                   memtoReg_out,
  output logic                   regDst_out,
  output logic                   regWrite_out,
  output logic                   aluSrcA_out,
  output logic [1:0]             aluSrcB_out,
  output logic [1:0]             aluOp_out,
  output logic [1:0]             pcSource_out,
  output logic [3:0]             state_out,
  output logic                   halted_out,
  output logic                   timeout_out,
  output logic [COUNT_WIDTH-1:0] instr_count_out
);

  import mips_mc_pkg::*;

  state_t                 state_q;
  state_t                 state_d;
  ctrl_t                  ctrl;
  ctrl_t                  ctrl_gated;
  logic                   timeout_q;
  logic                   timeout_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   expire;
  logic                   retire;

  mips_mc_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i   (clock_in),
    .rst_i   (reset_in),
    .active_i(is_mem_state(state_q)),
    .ready_i (mem_ready_in),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready_in;
        ctrl.pc_write  = mem_ready_in;
        if (mem_ready_in)  state_d = DECODE;
        else if (expire)   state_d = TRAP;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode_in)
          OP_RTYPE:    state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_ADDI:     state_d = ADDI_EX;
          OP_BEQ:      state_d = BRANCH;
          OP_J:        state_d = JUMP;
          default:     state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        if (opcode_in == OP_LW)      state_d = MEMREAD;
        else if (opcode_in == OP_SW) state_d = MEMWRITE;
        else                         state_d = TRAP;
      end
      MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready_in) state_d = MEMWB;
        else if (expire)  state_d = TRAP;
      end
      MEMWB: begin
        ctrl.memto_reg = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = FETCH;
      end
      MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready_in) state_d = FETCH;
        else if (expire)  state_d = TRAP;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = FETCH;
      end
      ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = ADDI_WB;
      end
      ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        state_d            = FETCH;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_d        = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // An instruction retires when its last step hands control back to FETCH.
  assign retire = (state_d == FETCH) && (state_q != IDLE) && (state_q != FETCH);

  always_comb begin
    timeout_d = timeout_q | expire;
    count_d   = retire ? count_q + COUNT_WIDTH'(1) : count_q;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  // Strobes drop combinationally under reset so an in-flight access is cut off at once.
  assign ctrl_gated = reset_in ? '0 : ctrl;

  assign pcWrite_out     = ctrl_gated.pc_write;
  assign pcWriteCond_out = ctrl_gated.pc_write_cond;
  assign iorD_out        = ctrl_gated.iord;
  assign memRead_out     = ctrl_gated.mem_read;
  assign memWrite_out    = ctrl_gated.mem_write;
  assign irWrite_out     = ctrl_gated.ir_write;
  assign memtoReg_out    = ctrl_gated.memto_reg;
  assign regDst_out      = ctrl_gated.reg_dst;
  assign regWrite_out    = ctrl_gated.reg_write;
  assign aluSrcA_out     = ctrl_gated.alu_src_a;
  assign aluSrcB_out     = ctrl_gated.alu_src_b;
  assign aluOp_out       = ctrl_gated.alu_op;
  assign pcSource_out    = ctrl_gated.pc_source;
  assign state_out       = state_q;
  assign halted_out      = (state_q == TRAP);
  assign timeout_out     = timeout_q;
  assign instr_count_out = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
// tb_mips_mc_control: directed vector table plus multi-cycle corner sequences.
// Rev 1.0
// ============================================================================
module tb_mips_mc_control;

  localparam logic [3:0] T_IDLE = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2, T_MEMADR = 4'd3;
  localparam logic [3:0] T_MEMREAD = 4'd4, T_MEMWB = 4'd5, T_MEMWRITE = 4'd6, T_EXECUTE = 4'd7;
  localparam logic [3:0] T_ALUWB = 4'd8, T_ADDI_EX = 4'd9, T_ADDI_WB = 4'd10, T_BRANCH = 4'd11;
  localparam logic [3:0] T_JUMP = 4'd12, T_TRAP = 4'd13;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000, O_BAD = 6'b111111;

  // {pcW, pcWC, iorD, mRd, mWr, irW, m2R, rDst, rW, srcA, srcB, aluOp, pcSrc}
  localparam logic [15:0] B_NONE     = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] B_FETCH_R  = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] B_FETCH_W  = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] B_DECODE   = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] B_MEMADR   = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] B_MEMREAD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] B_MEMWB    = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [15:0] B_MEMWRITE = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] B_EXECUTE  = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [15:0] B_ALUWB    = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [15:0] B_ADDI_WB  = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
  localparam logic [15:0] B_BRANCH   = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [15:0] B_JUMP     = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] sb;
    logic        halted;
    logic        tout;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        ready;
  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic        memtoReg, regDst, regWrite, aluSrcA;
  logic [1:0]  aluSrcB, aluOp, pcSource;
  logic [3:0]  state;
  logic        halted, tout;
  logic [31:0] icount;
  logic [15:0] strobes;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  mips_mc_control #(.COUNT_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clock_in(clk), .reset_in(rst), .opcode_in(opcode), .mem_ready_in(ready),
    .pcWrite_out(pcWrite), .pcWriteCond_out(pcWriteCond), .iorD_out(iorD),
    .memRead_out(memRead), .memWrite_out(memWrite), .irWrite_out(irWrite),
    .memtoReg_out(memtoReg), .regDst_out(regDst), .regWrite_out(regWrite),
    .aluSrcA_out(aluSrcA), .aluSrcB_out(aluSrcB), .aluOp_out(aluOp),
    .pcSource_out(pcSource), .state_out(state), .halted_out(halted),
    .timeout_out(tout), .instr_count_out(icount)
  );

  assign strobes = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg,
                    regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

  function automatic vec_t mk(input logic r, input logic [5:0] op, input logic rdy,
                              input logic [3:0] st, input logic [15:0] sb,
                              input logic h, input logic t, input logic [31:0] c);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.sb = sb;
    v.halted = h; v.tout = t; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, field, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check on the falling edge.
  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [15:0] sb, input logic h,
                     input logic t, input logic [31:0] c, input string tag);
    rst = r; opcode = op; ready = rdy;
    @(negedge clk);
    chk(tag, "state",   {28'd0, state},   {28'd0, st});
    chk(tag, "strobes", {16'd0, strobes}, {16'd0, sb});
    chk(tag, "halted",  {31'd0, halted},  {31'd0, h});
    chk(tag, "timeout", {31'd0, tout},    {31'd0, t});
    chk(tag, "count",   icount,           c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = O_R; ready = 1'b0;

    vq.push_back(mk(1, O_R,    1, T_IDLE,     B_NONE,     0, 0, 0));
    vq.push_back(mk(0, O_R,    1, T_IDLE,     B_NONE,     0, 0, 0));
    vq.push_back(mk(0, O_R,    1, T_FETCH,    B_FETCH_R,  0, 0, 0));
    vq.push_back(mk(0, O_R,    1, T_DECODE,   B_DECODE,   0, 0, 0));
    vq.push_back(mk(0, O_R,    1, T_EXECUTE,  B_EXECUTE,  0, 0, 0));
    vq.push_back(mk(0, O_R,    1, T_ALUWB,    B_ALUWB,    0, 0, 0));
    vq.push_back(mk(0, O_LW,   1, T_FETCH,    B_FETCH_R,  0, 0, 1));
    vq.push_back(mk(0, O_LW,   1, T_DECODE,   B_DECODE,   0, 0, 1));
    vq.push_back(mk(0, O_LW,   1, T_MEMADR,   B_MEMADR,   0, 0, 1));
    vq.push_back(mk(0, O_LW,   0, T_MEMREAD,  B_MEMREAD,  0, 0, 1));
    vq.push_back(mk(0, O_LW,   0, T_MEMREAD,  B_MEMREAD,  0, 0, 1));
    vq.push_back(mk(0, O_LW,   1, T_MEMREAD,  B_MEMREAD,  0, 0, 1));
    vq.push_back(mk(0, O_LW,   1, T_MEMWB,    B_MEMWB,    0, 0, 1));
    vq.push_back(mk(0, O_BEQ,  0, T_FETCH,    B_FETCH_W,  0, 0, 2));
    vq.push_back(mk(0, O_BEQ,  1, T_FETCH,    B_FETCH_R,  0, 0, 2));
    vq.push_back(mk(0, O_BEQ,  1, T_DECODE,   B_DECODE,   0, 0, 2));
    vq.push_back(mk(0, O_BEQ,  1, T_BRANCH,   B_BRANCH,   0, 0, 2));
    vq.push_back(mk(0, O_J,    1, T_FETCH,    B_FETCH_R,  0, 0, 3));
    vq.push_back(mk(0, O_J,    1, T_DECODE,   B_DECODE,   0, 0, 3));
    vq.push_back(mk(0, O_J,    1, T_JUMP,     B_JUMP,     0, 0, 3));
    vq.push_back(mk(0, O_ADDI, 1, T_FETCH,    B_FETCH_R,  0, 0, 4));
    vq.push_back(mk(0, O_ADDI, 1, T_DECODE,   B_DECODE,   0, 0, 4));
    vq.push_back(mk(0, O_ADDI, 1, T_ADDI_EX,  B_MEMADR,   0, 0, 4));
    vq.push_back(mk(0, O_ADDI, 1, T_ADDI_WB,  B_ADDI_WB,  0, 0, 4));
    vq.push_back(mk(0, O_SW,   1, T_FETCH,    B_FETCH_R,  0, 0, 5));
    vq.push_back(mk(0, O_SW,   1, T_DECODE,   B_DECODE,   0, 0, 5));
    vq.push_back(mk(0, O_SW,   1, T_MEMADR,   B_MEMADR,   0, 0, 5));
    vq.push_back(mk(0, O_SW,   1, T_MEMWRITE, B_MEMWRITE, 0, 0, 5));
    vq.push_back(mk(0, O_BAD,  1, T_FETCH,    B_FETCH_R,  0, 0, 6));
    vq.push_back(mk(0, O_BAD,  1, T_DECODE,   B_DECODE,   0, 0, 6));
    vq.push_back(mk(0, O_BAD,  1, T_TRAP,     B_NONE,     1, 0, 6));

    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rst, vq[i].op, vq[i].rdy, vq[i].st, vq[i].sb, vq[i].halted,
          vq[i].tout, vq[i].cnt, $sformatf("vec%0d", i));
    end

    // Illegal opcode trap is terminal whatever the inputs do.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), T_TRAP, B_NONE, 1, 0, 6,
          $sformatf("trap_hold%0d", i));
    end

    // SW that never gets ready: 16 wait cycles then a timeout trap.
    cyc(1, O_SW, 1, T_TRAP,     B_NONE,     1, 0, 6, "to_rst");
    cyc(0, O_SW, 1, T_IDLE,     B_NONE,     0, 0, 0, "to_idle");
    cyc(0, O_SW, 1, T_FETCH,    B_FETCH_R,  0, 0, 0, "to_fetch");
    cyc(0, O_SW, 1, T_DECODE,   B_DECODE,   0, 0, 0, "to_decode");
    cyc(0, O_SW, 1, T_MEMADR,   B_MEMADR,   0, 0, 0, "to_memadr");
    for (int i = 0; i < 16; i++) begin
      cyc(0, O_SW, 0, T_MEMWRITE, B_MEMWRITE, 0, 0, 0, $sformatf("to_wait%0d", i));
    end
    cyc(0, O_SW, 0, T_TRAP,     B_NONE,     1, 1, 0, "to_trap");
    cyc(0, O_SW, 1, T_TRAP,     B_NONE,     1, 1, 0, "to_trap2");

    // Reset landing in the middle of a write wait.
    cyc(1, O_SW, 0, T_TRAP,     B_NONE,     1, 1, 0, "mr_rst");
    cyc(0, O_SW, 1, T_IDLE,     B_NONE,     0, 0, 0, "mr_idle");
    cyc(0, O_SW, 1, T_FETCH,    B_FETCH_R,  0, 0, 0, "mr_fetch");
    cyc(0, O_SW, 1, T_DECODE,   B_DECODE,   0, 0, 0, "mr_decode");
    cyc(0, O_SW, 1, T_MEMADR,   B_MEMADR,   0, 0, 0, "mr_memadr");
    for (int i = 0; i < 3; i++) begin
      cyc(0, O_SW, 0, T_MEMWRITE, B_MEMWRITE, 0, 0, 0, $sformatf("mr_wait%0d", i));
    end
    cyc(1, O_SW, 0, T_MEMWRITE, B_NONE,     0, 0, 0, "mr_cut");
    cyc(0, O_SW, 0, T_IDLE,     B_NONE,     0, 0, 0, "mr_after");

    // Ready on the last allowed wait cycle wins over the timeout.
    for (int i = 0; i < 15; i++) begin
      cyc(0, O_R, 0, T_FETCH, B_FETCH_W, 0, 0, 0, $sformatf("lim_wait%0d", i));
    end
    cyc(0, O_R, 1, T_FETCH,   B_FETCH_R,  0, 0, 0, "lim_ready");
    cyc(0, O_R, 1, T_DECODE,  B_DECODE,   0, 0, 0, "lim_decode");
    cyc(0, O_R, 1, T_EXECUTE, B_EXECUTE,  0, 0, 0, "lim_exec");
    cyc(0, O_R, 1, T_ALUWB,   B_ALUWB,    0, 0, 0, "lim_aluwb");
    cyc(0, O_R, 1, T_FETCH,   B_FETCH_R,  0, 0, 1, "lim_retire");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
